// File: rtl/spart_pkg.sv
// Shared definitions for the mini SPART: frame geometry and transmit state encoding.
package spart_pkg;

  localparam int TX_DATA_BITS  = 8;
  localparam int TX_OVERSAMPLE = 16;
  localparam int FRAME_BITS    = 1 + TX_DATA_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

endpackage

// File: rtl/spart_tx_if.sv
// Bus-side write port of the SPART transmitter.
interface spart_tx_if #(
  parameter int DATA_BITS = 8
);

  // load is a one-clk write strobe; the byte on TxD_data is taken at that edge
  // only if TBR=1, otherwise it is dropped and overrun pulses for one clk.
  logic [DATA_BITS-1:0] TxD_data;
  logic                 load;
  logic                 TBR;
  logic                 overrun;

  modport master (
    output TxD_data,
    output load,
    input  TBR,
    input  overrun
  );

  modport slave (
    input  TxD_data,
    input  load,
    output TBR,
    output overrun
  );

endinterface

// File: rtl/spart_bit_timer.sv
// Counts Baud enables within one serial bit and flags the final tick of the bit.
module spart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_baud,
  output logic o_end_of_bit
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_baud_cnt;
  logic             w_tick;

  assign w_tick       = i_run & i_baud;
  assign o_end_of_bit = w_tick & (r_baud_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
    end else if (i_clear) begin
      r_baud_cnt <= '0;
    end else if (w_tick) begin
      r_baud_cnt <= (r_baud_cnt == LAST) ? '0 : r_baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding register feeding an 8N1 shifter on TxD.
module spart_tx
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = TX_DATA_BITS,
  parameter int OVERSAMPLE = TX_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Baud,
  spart_tx_if.slave  bus,
  output logic       TxD,
  output tx_state_t  o_state
);

  localparam int BIT_W = $clog2(DATA_BITS) + 1;

  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_hold_full;
  logic [BIT_W-1:0]     r_bit_cnt;
  tx_state_t            r_state;
  logic                 r_txd;
  logic                 r_overrun;

  logic w_end_of_bit;
  logic w_run;
  logic w_accept;
  logic w_stop_end;
  logic w_transfer;
  logic w_last_bit;

  assign w_run      = (r_state != IDLE);
  assign w_accept   = bus.load & ~r_hold_full;
  assign w_stop_end = (r_state == STOP) & w_end_of_bit;
  // A queued byte starts straight after the stop bit, so frames run back-to-back.
  assign w_transfer = r_hold_full & ((r_state == IDLE) | w_stop_end);
  assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_BITS - 1));

  assign bus.TBR     = ~r_hold_full;
  assign bus.overrun = r_overrun;
  assign TxD         = r_txd;
  assign o_state     = r_state;

  spart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_transfer),
    .i_run        (w_run),
    .i_baud       (Baud),
    .o_end_of_bit (w_end_of_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_state     <= IDLE;
      r_txd       <= 1'b1;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= bus.load & r_hold_full;

      if (w_accept) begin
        r_hold      <= bus.TxD_data;
        r_hold_full <= 1'b1;
      end

      if (w_transfer) begin
        r_shift     <= r_hold;
        r_hold_full <= 1'b0;
        r_bit_cnt   <= '0;
        r_state     <= START;
        r_txd       <= 1'b0;
      end else begin
        // TxD is loaded with the value of the state being entered.
        case (r_state)
          IDLE: begin
            r_txd <= 1'b1;
          end
          START: begin
            if (w_end_of_bit) begin
              r_state <= DATA;
              r_txd   <= r_shift[0];
            end
          end
          DATA: begin
            if (w_end_of_bit) begin
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              if (w_last_bit) begin
                r_state <= STOP;
                r_txd   <= 1'b1;
              end else begin
                r_txd <= r_shift[1];
              end
            end
          end
          STOP: begin
            if (w_end_of_bit) begin
              r_state <= IDLE;
              r_txd   <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
